// File: rtl/slice_acc_pkg.sv
// slice_acc_pkg: shared types and elaboration helpers for the slice accumulator.
// Optional feature macro: SLICE_ACC_SATURATE_EN (saturating arithmetic).
package slice_acc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } slice_acc_state_t;

   typedef enum logic {
      ACC_ADD = 1'b0,
      ACC_SUB = 1'b1
   } slice_acc_mode_t;

   // Number of clocks needed to walk all slices of one operand vector.
   function automatic int chunk_count(input int n_slices, input int per_cycle);
      return n_slices / per_cycle;
   endfunction

   // Counter width that can hold 0 .. n-1 (never narrower than one bit).
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/slice_acc_seq_if.sv
// slice_acc_seq_if: operand/result handshake bundle of the slice accumulator.
// Optional feature macro: SLICE_ACC_SATURATE_EN (affects the block, not this bundle).
interface slice_acc_seq_if #(
   parameter int WIDTH    = 10,
   parameter int N_SLICES = 48
);
   logic                         in_valid;
   logic                         in_ready;
   logic [N_SLICES*WIDTH-1:0]    in_data;
   logic                         in_mode;
   logic                         out_valid;
   logic                         out_ready;
   logic [WIDTH-1:0]             out_data;
   logic                         out_ovf;
   logic                         busy;

   // Producer/consumer side of the block.
   modport master (
      output in_valid, in_data, in_mode, out_ready,
      input  in_ready, out_valid, out_data, out_ovf, busy
   );

   // The accumulator itself.
   modport slave (
      input  in_valid, in_data, in_mode, out_ready,
      output in_ready, out_valid, out_data, out_ovf, busy
   );
endinterface

// File: rtl/slice_acc_chunk.sv
// slice_acc_chunk: combinational chain of SLICES_PER_CYCLE add/subtract stages.
// Optional feature macro: SLICE_ACC_SATURATE_EN clamps each stage instead of wrapping.
module slice_acc_chunk
   import slice_acc_pkg::*;
#(
   parameter int WIDTH            = 10,
   parameter int SLICES_PER_CYCLE = 4
) (
   input  logic [WIDTH-1:0]                  i_acc,
   input  logic [SLICES_PER_CYCLE*WIDTH-1:0] i_slices,
   input  slice_acc_mode_t                   i_mode,
   output logic [WIDTH-1:0]                  o_acc,
   output logic                              o_ovf
);

   logic [WIDTH:0]   w_stage;
   logic [WIDTH-1:0] w_acc;
   logic             w_ovf;

   // Apply the slices in ascending order; bit WIDTH of each stage is carry/borrow.
   always_comb begin
      // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
      w_acc   = i_acc;
      w_ovf   = 1'b0;
      w_stage = '0;
      for (int k = 0; k < SLICES_PER_CYCLE; k++) begin
         if (i_mode == ACC_SUB) begin
            w_stage = {1'b0, w_acc} - {1'b0, i_slices[k*WIDTH +: WIDTH]};
         end else begin
            w_stage = {1'b0, w_acc} + {1'b0, i_slices[k*WIDTH +: WIDTH]};
         end
`ifdef SLICE_ACC_SATURATE_EN
         if (w_stage[WIDTH]) begin
            w_acc = (i_mode == ACC_SUB) ? '0 : '1;
         end else begin
            w_acc = w_stage[WIDTH-1:0];
         end
`else
         w_acc = w_stage[WIDTH-1:0];
`endif
         w_ovf = w_ovf | w_stage[WIDTH];
      end
   end

   assign o_acc = w_acc;
   assign o_ovf = w_ovf;

endmodule

// File: rtl/slice_acc_seq.sv
// slice_acc_seq: time-multiplexed slice accumulator with valid/ready handshakes.
// Optional feature macro: SLICE_ACC_SATURATE_EN (saturating instead of modulo arithmetic).
module slice_acc_seq
   import slice_acc_pkg::*;
#(
   parameter int WIDTH            = 10,
   parameter int N_SLICES         = 48,
   parameter int SLICES_PER_CYCLE = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   slice_acc_seq_if.slave bus
);

   localparam int N_CHUNKS = chunk_count(N_SLICES, SLICES_PER_CYCLE);
   localparam int CNT_W    = cnt_width(N_CHUNKS);
   localparam int CHUNK_W  = SLICES_PER_CYCLE * WIDTH;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_CHUNKS - 1);

   generate
      if ((SLICES_PER_CYCLE < 1) || (N_SLICES % SLICES_PER_CYCLE != 0)) begin : g_bad_cfg
         $error("slice_acc_seq: SLICES_PER_CYCLE must divide N_SLICES");
      end
   endgenerate

   slice_acc_state_t          r_state;
   slice_acc_state_t          w_next_state;
   logic [N_SLICES*WIDTH-1:0] r_data;
   slice_acc_mode_t           r_mode;
   logic [WIDTH-1:0]          r_acc;
   logic                      r_ovf;
   logic [CNT_W-1:0]          r_cnt;
   logic [WIDTH-1:0]          r_out_data;
   logic                      r_out_ovf;
   logic [WIDTH-1:0]          w_chunk_acc;
   logic                      w_chunk_ovf;

   // The lowest chunk of the shifting operand register is always the next one to process.
   slice_acc_chunk #(
      .WIDTH            (WIDTH),
      .SLICES_PER_CYCLE (SLICES_PER_CYCLE)
   ) u_chunk (
      .i_acc    (r_acc),
      .i_slices (r_data[CHUNK_W-1:0]),
      .i_mode   (r_mode),
      .o_acc    (w_chunk_acc),
      .o_ovf    (w_chunk_ovf)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode: accept in IDLE, leave ACCUM after the last chunk, release on out_ready.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (bus.in_valid)        w_next_state = ACCUM;
         ACCUM:   if (r_cnt == LAST_CNT)   w_next_state = DONE;
         DONE:    if (bus.out_ready)       w_next_state = IDLE;
         default:                          w_next_state = IDLE;
      endcase
   end

   // Datapath: capture operand, fold one chunk per clock, latch the result on the last chunk.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the wide operand register is reset as well, so an aborted operation leaves no stale operand behind.
      if (!rst_n) begin
         r_data     <= '0;
         r_mode     <= ACC_ADD;
         r_acc      <= '0;
         r_ovf      <= 1'b0;
         r_cnt      <= '0;
         r_out_data <= '0;
         r_out_ovf  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_data <= bus.in_data;
                  r_mode <= slice_acc_mode_t'(bus.in_mode);
                  r_acc  <= '0;
                  r_ovf  <= 1'b0;
                  r_cnt  <= '0;
               end
            end
            ACCUM: begin
               r_data <= r_data >> CHUNK_W;
               r_acc  <= w_chunk_acc;
               r_ovf  <= r_ovf | w_chunk_ovf;
               r_cnt  <= r_cnt + 1'b1;
               if (r_cnt == LAST_CNT) begin
                  r_out_data <= w_chunk_acc;
                  r_out_ovf  <= r_ovf | w_chunk_ovf;
               end
            end
            default: ;
         endcase
      end
   end

   // Handshake flags are decoded from the state register only; results come from output registers.
   assign bus.in_ready  = (r_state == IDLE);
   assign bus.out_valid = (r_state == DONE);
   assign bus.busy      = (r_state != IDLE);
   assign bus.out_data  = r_out_data;
   assign bus.out_ovf   = r_out_ovf;

endmodule

// File: doc/slice_acc_seq.md
# slice_acc_seq

Sequential, parametrised slice accumulator. It accepts a wide vector of `N_SLICES` unsigned `WIDTH`-bit slices and adds or subtracts all of them, starting from zero. It processes `SLICES_PER_CYCLE` slices per clock and returns one `WIDTH`-bit result through a valid/ready handshake. It generalises the combinational slice-difference datapath into a time-multiplexed, mode-selectable block for area-constrained, triplicated designs.

## Interface
- `WIDTH`, 10: bit width of each slice, the accumulator and the result.
- `N_SLICES`, 48: number of slices per operand vector.
- `SLICES_PER_CYCLE`, 4: slices consumed per clock. Must divide `N_SLICES`; elaboration fails otherwise.
- `clk`, input, 1: clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `in_valid`, input, 1: operand vector valid.
- `in_ready`, output, 1: block can accept an operand.
- `in_data`, input, `N_SLICES*WIDTH`: slice k is `in_data[k*WIDTH +: WIDTH]`.
- `in_mode`, input, 1: 0 = accumulate `+=`; 1 = accumulate `-=`.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: consumer accepts the result.
- `out_data`, output, `WIDTH`: result.
- `out_ovf`, output, 1: at least one wrap or saturation occurred during this operation.
- `busy`, output, 1: high whenever the FSM is not in IDLE.

## Operation
- The FSM has three states: IDLE, ACCUM and DONE. Reset puts it in IDLE.
- **Reset values:** `in_ready`=1, `out_valid`=0, `out_data`=0, `out_ovf`=0, `busy`=0. The internal accumulator, slice counter and operand register all reset to 0.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid && in_ready` the block registers `in_data` and `in_mode`, clears the accumulator and the overflow flag, sets counter=0 and moves to ACCUM.
- **ACCUM:**
  - `in_ready`=0.
  - Each clock processes slices `counter*SLICES_PER_CYCLE` through `counter*SLICES_PER_CYCLE + SLICES_PER_CYCLE - 1`, in ascending index order.
  - Each slice updates the accumulator as `acc = acc ± slice`.
  - Then counter increments.
  - After the chunk with counter = `N_SLICES/SLICES_PER_CYCLE - 1`, the block loads `out_data` and `out_ovf` and moves to DONE.
- **DONE:**
  - `out_valid`=1. `out_data` and `out_ovf` are held stable until the handshake.
  - On `out_ready` the block returns to IDLE.
  - `in_ready` stays 0 in DONE; there is no same-cycle overlap.
- **Arithmetic:** unsigned, `WIDTH` bits.
  - Default behaviour: modulo 2^`WIDTH`.
  - `out_ovf` is set if any add carries out or any subtract borrows.
- Input changes outside the acceptance edge have no effect. `in_data` does not need to be held after acceptance.
- `out_ready` asserted outside DONE is ignored.
- Reset asserted mid-operation aborts immediately. The result is discarded and no `out_valid` pulse is produced.

## Timing
- Acceptance edge E0. Chunk edges are E1 through E`N_SLICES/SLICES_PER_CYCLE`. `out_valid` rises after the last chunk edge. With default parameters that is 12 clocks after E0.
- Output handshake edge H: `out_valid` falls and `in_ready` rises after H. The next operand can be accepted on edge H+1.
- Minimum period per operation is `N_SLICES/SLICES_PER_CYCLE + 2` clocks. With default parameters that is 14.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `SLICE_ACC_SATURATE_EN`.
- **Defined:** saturating arithmetic, applied per slice in processing order.
  - `+=` clamps at 2^`WIDTH`-1.
  - `-=` clamps at 0.
  - Once clamped, accumulation continues from the clamped value.
  - `out_ovf` is set if any clamp occurred.
- **Undefined:** modulo arithmetic as described under Operation. No saturation logic is present.

## Structure
- Package `slice_acc_pkg` holds:
  - the state enum `slice_acc_state_t` (IDLE, ACCUM, DONE);
  - the mode enum `slice_acc_mode_t` (ACC_ADD, ACC_SUB);
  - the localparam function that computes the chunk count.
- Sub-module `slice_acc_chunk`: purely combinational. It chains `SLICES_PER_CYCLE` add/subtract stages with optional saturation and returns the updated accumulator plus a per-chunk overflow flag.
- The top level holds the FSM, counter, operand register and output registers.

## Test plan
All scenarios use default parameters.
1. **Add, all slices = 1, modulo build:** `out_data`=48, `out_ovf`=0, `out_valid` 12 clocks after acceptance.
2. **Subtract, all slices = 1, modulo build:** `out_data`=976, `out_ovf`=1.
3. **Add, all slices = 1023:**
   - Modulo build: `out_data`=976, `out_ovf`=1.
   - `SLICE_ACC_SATURATE_EN` build: `out_data`=1023, `out_ovf`=1.
4. **Subtract, all slices = 1, `SLICE_ACC_SATURATE_EN` build:** `out_data`=0, `out_ovf`=1.
5. **Backpressure and back-to-back:**
   - Hold `out_ready`=0 for 5 clocks: `out_data` stays stable and `in_ready` stays 0.
   - Then assert `out_ready` and present a second operand on H+1: the operand is accepted on H+1 and its result is correct.
6. **Reset mid-operation:** assert `rst_n`=0 at chunk 6. All outputs return to reset values, no `out_valid` is produced, and `in_ready`=1 after reset is released.
